// File: rtl/capture_buffer.sv
// capture_buffer: level-triggered ADC frame capture with decimation; each completed frame is
// published as a stable registered array. Define CAPTURE_BUFFER_AUTO_TRIG_EN for the ARMED timeout trigger.
module capture_buffer #(
  parameter int unsigned SAMPLES = 80,
  parameter int unsigned DW = 12
`ifdef CAPTURE_BUFFER_AUTO_TRIG_EN
  ,
  parameter int unsigned AUTO_TIMEOUT = 4096
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] trig_level,
  input  logic [7:0]    decim,
  input  logic          arm,
  input  logic          continuous,
  output logic [DW-1:0] data [0:SAMPLES-1],
  output logic          frame_valid,
  output logic          busy,
  output logic          triggered
);

  localparam int unsigned IW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, PUBLISH} state_t;

  state_t        state;
  logic [DW-1:0] frame_buf [0:SAMPLES-1];
  logic [DW-1:0] prev;
  logic          prev_ok;
  logic [IW-1:0] idx;
  logic [7:0]    dcnt;
  logic [7:0]    decim_q;
  logic          level_trig;
  logic          fire;

  // Rising crossing: previous valid sample below threshold, current one at or above it.
  assign level_trig = sample_valid && prev_ok && (prev < trig_level) && (sample >= trig_level);

`ifdef CAPTURE_BUFFER_AUTO_TRIG_EN
  localparam int unsigned TW = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

  logic [TW-1:0] tcnt;

  // Counts valid samples while ARMED; any other state holds it at zero, so it restarts on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state != ARMED) begin
      tcnt <= '0;
    end else if (sample_valid) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign fire = level_trig || (sample_valid && (tcnt == TW'(AUTO_TIMEOUT - 1)));
`else
  assign fire = level_trig;
`endif

  // Capture FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prev        <= '0;
      prev_ok     <= 1'b0;
      idx         <= '0;
      dcnt        <= '0;
      decim_q     <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      triggered   <= 1'b0;
      for (int unsigned i = 0; i < SAMPLES; i++) begin
        frame_buf[i] <= '0;
        data[i]      <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state   <= ARMED;
            prev_ok <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ARMED: begin
          if (sample_valid) begin
            prev    <= sample;
            prev_ok <= 1'b1;
            if (fire) begin
              frame_buf[0] <= sample;
              idx          <= IW'(1);
              dcnt         <= '0;
              decim_q      <= decim;
              state        <= CAPTURE;
              triggered    <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
            if (dcnt == decim_q) begin
              frame_buf[idx] <= sample;
              dcnt           <= '0;
              if (idx == IW'(SAMPLES - 1)) begin
                state <= PUBLISH;
              end else begin
                idx <= idx + IW'(1);
              end
            end else begin
              dcnt <= dcnt + 8'd1;
            end
          end
        end
        PUBLISH: begin
          // Samples arriving this cycle are intentionally dropped.
          for (int unsigned i = 0; i < SAMPLES; i++) begin
            data[i] <= frame_buf[i];
          end
          frame_valid <= 1'b1;
          triggered   <= 1'b0;
          if (continuous) begin
            state   <= ARMED;
            prev_ok <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_buffer.sv
// tb_capture_buffer: directed + randomized stimulus against a frame-level reference model
// that derives each expected frame from the recorded per-cycle input stream.
module tb_capture_buffer;
  localparam int N = 80;
  localparam int W = 12;
`ifdef CAPTURE_BUFFER_AUTO_TRIG_EN
  localparam int AT = 16;
`endif

  logic         clk = 1'b0;
  logic         rst, sample_valid, arm, continuous;
  logic [W-1:0] sample, trig_level;
  logic [7:0]   decim;
  logic [W-1:0] data [0:N-1];
  logic         frame_valid, busy, triggered;

  always #5 clk = ~clk;

  capture_buffer #(
    .SAMPLES(N),
    .DW(W)
`ifdef CAPTURE_BUFFER_AUTO_TRIG_EN
    ,
    .AUTO_TIMEOUT(AT)
`endif
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .trig_level(trig_level), .decim(decim), .arm(arm), .continuous(continuous),
    .data(data), .frame_valid(frame_valid), .busy(busy), .triggered(triggered)
  );

  int           n_cmp = 0;
  int           n_bad = 0;
  int           gcyc = 0;
  logic         in_v[$];
  logic [W-1:0] in_s[$];
  logic [W-1:0] in_l[$];
  logic [7:0]   in_d[$];
  logic         obs_fv[$], obs_busy[$], obs_trig[$];
  int           fv_cyc[$];
  logic [W-1:0] snaps[$];
  logic [W-1:0] pre[$];
  logic [W-1:0] pub [0:N-1];
  logic [W-1:0] exp_fr [0:N-1];
  logic         unstable;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] snap(input int fi, input int j);
    return snaps[fi*N + j];
  endfunction

  // One cycle: observe outputs at the negedge, then drive the next inputs and log them.
  task automatic step(input logic r, input logic a, input logic v, input logic [W-1:0] s,
                      input logic [W-1:0] l, input logic [7:0] d);
    @(negedge clk);
    obs_fv.push_back(frame_valid);
    obs_busy.push_back(busy);
    obs_trig.push_back(triggered);
    if (frame_valid === 1'b1) begin
      fv_cyc.push_back(gcyc);
      for (int i = 0; i < N; i++) begin
        snaps.push_back(data[i]);
        pub[i] = data[i];
      end
    end else begin
      for (int i = 0; i < N; i++) if (data[i] !== pub[i]) unstable = 1'b1;
    end
    rst = r; arm = a; sample_valid = v; sample = s; trig_level = l; decim = d;
    in_v.push_back(v); in_s.push_back(s); in_l.push_back(l); in_d.push_back(d);
    if (r) for (int i = 0; i < N; i++) pub[i] = '0;
    gcyc++;
  endtask

  // Reference: list the valid samples seen since arming, find the first trigger, then take
  // every (decim+1)-th valid sample after it. tg/lg are the cycles of trigger and final store.
  task automatic predict(input int st, output int tg, output int lg);
    int vi[$];
    int k;
    int p;
    int d;
    tg = -1; lg = -1; k = -1;
    for (int g = st; g < gcyc; g++) if (in_v[g]) vi.push_back(g);
    for (int i = 0; i < vi.size(); i++) begin
      if (i > 0 && in_s[vi[i-1]] < in_l[vi[i]] && in_s[vi[i]] >= in_l[vi[i]]) begin
        k = i; break;
      end
`ifdef CAPTURE_BUFFER_AUTO_TRIG_EN
      if (i == AT - 1) begin
        k = i; break;
      end
`endif
    end
    if (k < 0) return;
    d = int'(in_d[vi[k]]) + 1;
    for (int j = 0; j < N; j++) begin
      p = k + j*d;
      if (p >= vi.size()) return;
      exp_fr[j] = in_s[vi[p]];
      lg = vi[p];
    end
    tg = vi[k];
  endtask

  // kind 0: ramp/sawtooth from v0 by stp wrapping above top; kind 1: uniform random samples.
  task automatic stream(input int kind, input int v0, input int stp, input int top,
                        input logic [W-1:0] lvl, input logic [7:0] dfix, input bit rand_d,
                        input int stall, input int nmax, input bit stop_fv);
    int val = v0;
    int n = 0;
    int nfv = fv_cyc.size();
    logic v;
    logic [W-1:0] s;
    logic [7:0] d;
    while (n < nmax && !(stop_fv && fv_cyc.size() != nfv)) begin
      v = ($urandom_range(99) >= 32'(stall));
      s = W'($urandom_range(4095));
      if (v) begin
        if (pre.size() > 0) s = pre.pop_front();
        else if (kind == 0) begin
          s = W'(val);
          val += stp;
          if (val > top) val = 0;
        end
      end
      d = rand_d ? 8'($urandom_range(3)) : dfix;
      step(1'b0, 1'b0, v, s, lvl, d);
      n++;
    end
  endtask

  task automatic cmp_frame(input string tag, input int fi);
    for (int j = 0; j < N; j++) chk($sformatf("%s_d%0d", tag, j), snap(fi, j), exp_fr[j]);
  endtask

  task automatic chk_data_zero(input string tag);
    for (int j = 0; j < N; j++) chk($sformatf("%s_d%0d", tag, j), data[j], 0);
  endtask

  // Single-shot capture: arm, stream until a frame appears, check it against the model.
  task automatic single(input string tag, input int kind, input int v0, input int stp,
                        input logic [W-1:0] lvl, input logic [7:0] dfix, input bit rand_d,
                        input int stall, output int fi, output int st);
    int nfv, tg, lg, fc;
    step(1'b0, 1'b1, 1'b0, '0, lvl, dfix);
    st = gcyc;
    nfv = fv_cyc.size();
    stream(kind, v0, stp, 4095, lvl, dfix, rand_d, stall, 3000, 1'b1);
    step(1'b0, 1'b0, 1'b1, '0, lvl, dfix);
    step(1'b0, 1'b0, 1'b1, '0, lvl, dfix);
    chk({tag, "_frames"}, fv_cyc.size() - nfv, 1);
    fi = (fv_cyc.size() > nfv) ? nfv : -1;
    predict(st, tg, lg);
    if (fi >= 0) begin
      fc = fv_cyc[fi];
      chk({tag, "_frame_expected"}, tg >= 0, 1);
      if (tg >= 0) begin
        chk({tag, "_latency"}, fc, lg + 2);
        cmp_frame(tag, fi);
        chk({tag, "_trig_pre"}, obs_trig[tg], 0);
        chk({tag, "_trig_post"}, obs_trig[tg+1], 1);
        chk({tag, "_busy_armed"}, obs_busy[tg], 1);
      end
      chk({tag, "_fv_pulse"}, obs_fv[fc+1], 0);
      chk({tag, "_busy_after"}, obs_busy[fc+1], 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fi, st, nfv, tg, lg, i, nexp, cnt_fv, cnt_busy;
    bit done;
    rst = 1'b1; arm = 1'b0; sample_valid = 1'b0; sample = '0; trig_level = '0;
    decim = '0; continuous = 1'b0; unstable = 1'b0;
    for (int j = 0; j < N; j++) pub[j] = '0;

    // Reset, then idle with arm low.
    step(1'b1, 1'b0, 1'b0, '0, 12'd100, 8'd0);
    step(1'b1, 1'b0, 1'b0, '0, 12'd100, 8'd0);
    chk("rst_busy", obs_busy[1], 0);
    chk("rst_trig", obs_trig[1], 0);
    chk("rst_fv", obs_fv[1], 0);
    chk_data_zero("rst");
    cnt_fv = 0; cnt_busy = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'($urandom_range(1)), W'($urandom_range(4095)), 12'd100, 8'd0);
      if (obs_fv[gcyc-1] !== 1'b0) cnt_fv++;
      if (obs_busy[gcyc-1] !== 1'b0) cnt_busy++;
    end
    chk("idle_fv", cnt_fv, 0);
    chk("idle_busy", cnt_busy, 0);
    chk_data_zero("idle");

    // Ramp, every sample stored.
    single("ramp_d0", 0, 0, 10, 12'd100, 8'd0, 1'b0, 0, fi, st);
    if (fi >= 0) begin
      chk("ramp_d0_first", snap(fi, 0), 100);
      chk("ramp_d0_last", snap(fi, 79), 890);
    end

    // The first 150 after arming cannot trigger; the second one does.
    pre = '{12'd150, 12'd50, 12'd150};
    single("seq", 0, 160, 10, 12'd100, 8'd0, 1'b0, 0, fi, st);
    chk("seq_no_trig1", obs_trig[st+1], 0);
    chk("seq_no_trig2", obs_trig[st+2], 0);
    chk("seq_trig3", obs_trig[st+3], 1);
    if (fi >= 0) begin
      chk("seq_first", snap(fi, 0), 150);
      chk("seq_second", snap(fi, 1), 160);
    end

    // Random samples, random level, decim changing every cycle, random stalls.
    for (int r = 0; r < 2; r++)
      single($sformatf("rand%0d", r), 1, 0, 0, W'($urandom_range(3500, 500)), 8'd0, 1'b1, 25,
             fi, st);

    // Continuous mode on a sawtooth.
    continuous = 1'b1;
    unstable = 1'b0;
    step(1'b0, 1'b1, 1'b0, '0, 12'd100, 8'd0);
    st = gcyc;
    nfv = fv_cyc.size();
    stream(0, 0, 50, 4000, 12'd100, 8'd0, 1'b0, 10, 900, 1'b0);
    i = nfv; nexp = 0; done = 1'b0;
    while (!done) begin
      predict(st, tg, lg);
      if (tg < 0 || lg + 2 >= gcyc) done = 1'b1;
      else begin
        if (i < fv_cyc.size()) begin
          chk($sformatf("cont%0d_latency", nexp), fv_cyc[i], lg + 2);
          cmp_frame($sformatf("cont%0d", nexp), i);
        end
        i++; nexp++;
        st = lg + 2;
      end
    end
    chk("cont_frames", fv_cyc.size() - nfv, nexp);
    chk("cont_several", nexp >= 2, 1);
    chk("cont_stable", unstable, 0);
    chk("cont_busy", obs_busy[gcyc-1], 1);
    continuous = 1'b0;
    step(1'b1, 1'b0, 1'b0, '0, 12'd100, 8'd0);
    step(1'b0, 1'b0, 1'b0, '0, 12'd100, 8'd0);
    chk("cont_rst_busy", obs_busy[gcyc-1], 0);

    // Decimated ramp with stalls.
    single("ramp_d2", 0, 0, 10, 12'd100, 8'd2, 1'b0, 20, fi, st);
    if (fi >= 0) begin
      chk("ramp_d2_first", snap(fi, 0), 100);
      chk("ramp_d2_second", snap(fi, 1), 130);
      chk("ramp_d2_last", snap(fi, 79), 2470);
    end

    // Reset in the middle of a capture, with idx at 40.
    step(1'b0, 1'b1, 1'b0, '0, 12'd100, 8'd0);
    for (int k = 0; k < 50; k++) step(1'b0, 1'b0, 1'b1, W'(k*10), 12'd100, 8'd0);
    step(1'b1, 1'b0, 1'b1, 12'd500, 12'd100, 8'd0);
    chk("midcap_trig_before", obs_trig[gcyc-1], 1);
    step(1'b0, 1'b0, 1'b1, 12'd510, 12'd100, 8'd0);
    chk("midcap_busy", obs_busy[gcyc-1], 0);
    chk("midcap_trig", obs_trig[gcyc-1], 0);
    chk("midcap_fv", obs_fv[gcyc-1], 0);
    chk_data_zero("midcap");
    cnt_fv = 0; cnt_busy = 0;
    for (int k = 0; k < 100; k++) begin
      step(1'b0, 1'b0, 1'b1, W'(520 + k*10), 12'd100, 8'd0);
      if (obs_fv[gcyc-1] !== 1'b0) cnt_fv++;
      if (obs_busy[gcyc-1] !== 1'b0) cnt_busy++;
    end
    chk("midcap_after_fv", cnt_fv, 0);
    chk("midcap_after_busy", cnt_busy, 0);

`ifdef CAPTURE_BUFFER_AUTO_TRIG_EN
    // Constant input below the level: forced trigger on the AT-th valid sample.
    single("auto", 0, 5, 0, 12'd100, 8'd0, 1'b0, 20, fi, st);
    begin
      int c16, cnt;
      c16 = -1; cnt = 0;
      for (int g = st; g < gcyc; g++) if (in_v[g]) begin
        cnt++;
        if (cnt == AT) begin
          c16 = g; break;
        end
      end
      if (c16 >= 0) begin
        chk("auto_trig_pre", obs_trig[c16], 0);
        chk("auto_trig_post", obs_trig[c16+1], 1);
      end
      if (fi >= 0) for (int j = 0; j < N; j++) chk($sformatf("auto_const_d%0d", j), snap(fi, j), 5);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
